// File: rtl/ecc_write_encoder_if.sv
// Write-side bus for the SECDED write encoder: request port, SRAM write port,
// error-injection controls and the completed-write counter.
interface ecc_write_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [63:0]       wr_data;

   logic              sram_ready;
   logic              sram_we;
   logic [ADDR_W-1:0] sram_addr;
   logic [63:0]       sramdata;
   logic [7:0]        checkbits;

   logic              inj_arm;
   logic [71:0]       inj_mask;
   logic              inj_pending;
   logic [15:0]       enc_count;

   modport slave (
      input  wr_valid, wr_addr, wr_data, sram_ready, inj_arm, inj_mask,
      output wr_ready, sram_we, sram_addr, sramdata, checkbits, inj_pending, enc_count
   );

   modport master (
      output wr_valid, wr_addr, wr_data, sram_ready, inj_arm, inj_mask,
      input  wr_ready, sram_we, sram_addr, sramdata, checkbits, inj_pending, enc_count
   );
endinterface

// File: rtl/ecc_write_encoder.sv
// Two-stage Hamming(72,64) SECDED write encoder with one-shot error injection.
// S1 captures the request and the seven position parities; S2 adds overall parity and drives the SRAM.
module ecc_write_encoder #(
   parameter int ADDR_W = 10
) (
   input logic                 clk,
   input logic                 rst,
   ecc_write_encoder_if.slave  bus
);

   // Data bit k sits at the k-th non-power-of-two codeword position (3,5,6,7,9,...);
   // each position contributes to every check bit whose index is set in the position.
   function automatic logic [6:0] hamming_par(input logic [63:0] d);
      logic [6:0] p;
      int         k;
      p = '0;
      k = 0;
      for (int pos = 1; pos < 72; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            p = p ^ ({7{d[k[5:0]]}} & 7'(pos));
            k++;
         end
      end
      return p;
   endfunction

   logic              run;
   logic              s1_valid;
   logic [ADDR_W-1:0] s1_addr;
   logic [63:0]       s1_data;
   logic [6:0]        s1_par;
   logic [71:0]       s1_mask;

   logic              s2_valid;
   logic [ADDR_W-1:0] s2_addr;
   logic [63:0]       s2_data;
   logic [7:0]        s2_cb;

   logic              inj_pend;
   logic [71:0]       inj_mask_q;
   logic [15:0]       count;

   logic              s1_adv;
   logic              accept;
   logic              transfer;
   logic              ready;
   logic [6:0]        par_in;
   logic [7:0]        cb_full;

   assign transfer = s2_valid && bus.sram_ready;
   assign s1_adv   = !s2_valid || bus.sram_ready;
   // run keeps the port closed while in reset and opens it on the first edge after release
   assign ready    = run && (!s1_valid || s1_adv);
   assign accept   = bus.wr_valid && ready;
   assign par_in   = hamming_par(bus.wr_data);
   assign cb_full  = {^{s1_data, s1_par}, s1_par};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run      <= 1'b0;
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s1_data  <= '0;
         s1_par   <= '0;
         s1_mask  <= '0;
      end else begin
         run <= 1'b1;
         if (ready) s1_valid <= bus.wr_valid;
         if (accept) begin
            s1_addr <= bus.wr_addr;
            s1_data <= bus.wr_data;
            s1_par  <= par_in;
            s1_mask <= inj_pend ? inj_mask_q : '0;
         end
      end
   end

   // An arm in the same cycle as an acceptance is meant for the next request, so it wins over the clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inj_pend   <= 1'b0;
         inj_mask_q <= '0;
      end else if (bus.inj_arm) begin
         inj_pend   <= 1'b1;
         inj_mask_q <= bus.inj_mask;
      end else if (accept) begin
         inj_pend   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_addr  <= '0;
         s2_data  <= '0;
         s2_cb    <= '0;
      end else if (s1_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_addr <= s1_addr;
            s2_data <= s1_data ^ s1_mask[63:0];
            s2_cb   <= cb_full ^ s1_mask[71:64];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (transfer && (count != 16'hFFFF)) begin
         count <= count + 16'd1;
      end
   end

   assign bus.wr_ready    = ready;
   assign bus.sram_we     = s2_valid;
   assign bus.sram_addr   = s2_addr;
   assign bus.sramdata    = s2_data;
   assign bus.checkbits   = s2_cb;
   assign bus.inj_pending = inj_pend;
   assign bus.enc_count   = count;

endmodule

// File: tb/tb_ecc_write_encoder.sv
// Directed bench for ecc_write_encoder: expected writes are queued at acceptance
// and compared against every SRAM transfer by a monitor.
module tb_ecc_write_encoder;
   localparam int ADDR_W = 10;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [63:0]       data;
      logic [7:0]        cb;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ecc_write_encoder_if #(.ADDR_W(ADDR_W)) bus ();
   ecc_write_encoder #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference encoder built from an explicit codeword layout.
   function automatic logic [7:0] ref_cb(input logic [63:0] d);
      logic [71:0] cw;
      logic [7:0]  cb;
      int          k;
      cw = '0;
      cb = '0;
      k  = 0;
      for (int pos = 1; pos <= 71; pos++) begin
         if (pos != 1 && pos != 2 && pos != 4 && pos != 8 && pos != 16 && pos != 32 && pos != 64) begin
            if (((d >> k) & 64'd1) != 64'd0) cw = cw | (72'd1 << pos);
            k++;
         end
      end
      for (int i = 0; i < 7; i++)
         for (int pos = 1; pos <= 71; pos++)
            if ((pos & (1 << i)) != 0 && ((cw >> pos) & 72'd1) != 72'd0)
               cb = cb ^ (8'd1 << i);
      if ((^d) ^ (^cb[6:0])) cb = cb | 8'h80;
      return cb;
   endfunction

   logic        held_valid = 1'b0;
   logic [95:0] held = '0;
   exp_t        e;

   always @(negedge clk) begin
      if (held_valid && !rst)
         check("stall_hold", 96'({bus.sram_addr, bus.checkbits, bus.sramdata}), held);
      held_valid = bus.sram_we && !bus.sram_ready && !rst;
      held       = 96'({bus.sram_addr, bus.checkbits, bus.sramdata});
      if (bus.sram_we && bus.sram_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_write", 96'(bus.sram_we), 96'd0);
         end else begin
            e = sb.pop_front();
            check("wr_addr", 96'(bus.sram_addr), 96'(e.addr));
            check("wr_data", 96'(bus.sramdata), 96'(e.data));
            check("wr_cb", 96'(bus.checkbits), 96'(e.cb));
         end
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input logic [ADDR_W-1:0] a, input logic [63:0] d, input logic [7:0] cb);
      logic rdy;
      logic done;
      done = 1'b0;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         rdy = bus.wr_ready;
         @(posedge clk);
         if (rdy) begin
            sb.push_back('{addr: a, data: d, cb: cb});
            done = 1'b1;
         end
         #1;
      end
      if (!done) check("send_timeout", 96'(done), 96'd1);
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
      check("drain", 96'(sb.size()), 96'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        rdy;
      int          n;
      int          low;
      int          cyc;
      logic [63:0] d;

      bus.wr_valid   = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.sram_ready = 1'b1;
      bus.inj_arm    = 1'b0;
      bus.inj_mask   = '0;

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_we", 96'(bus.sram_we), 96'd0);
      check("rst_ready", 96'(bus.wr_ready), 96'd0);
      check("rst_pending", 96'(bus.inj_pending), 96'd0);
      check("rst_count", 96'(bus.enc_count), 96'd0);
      check("rst_data", 96'(bus.sramdata), 96'd0);
      check("rst_cb", 96'(bus.checkbits), 96'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_rst", 96'(bus.wr_ready), 96'd1);

      // two-cycle latency, all-zero data
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 10'd5;
      bus.wr_data  = 64'h0;
      sb.push_back('{addr: 10'd5, data: 64'h0, cb: 8'h00});
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b0;
      @(negedge clk);
      check("lat_cycle1_we", 96'(bus.sram_we), 96'd0);
      @(negedge clk);
      check("lat_cycle2_we", 96'(bus.sram_we), 96'd1);
      @(posedge clk);
      #1;

      send(10'd6, 64'h1, 8'h83);
      send(10'd7, 64'h2, 8'h85);
      wait_drain();
      check("count_3", 96'(bus.enc_count), 96'd3);

      // eight back-to-back writes with a three-cycle SRAM stall once both stages are full
      n = 0; low = 0; cyc = 0;
      bus.wr_valid = 1'b1;
      while (n < 8 && cyc < 100) begin
         d = {$urandom, $urandom};
         bus.sram_ready = !(cyc >= 4 && cyc <= 6);
         bus.wr_addr    = ADDR_W'(100 + n);
         bus.wr_data    = d;
         @(negedge clk);
         rdy = bus.wr_ready;
         if (!rdy) low++;
         @(posedge clk);
         if (rdy) begin
            sb.push_back('{addr: ADDR_W'(100 + n), data: d, cb: ref_cb(d)});
            n++;
         end
         #1;
         cyc++;
      end
      bus.wr_valid   = 1'b0;
      bus.sram_ready = 1'b1;
      wait_drain();
      check("stream_accepted", 96'(n), 96'd8);
      check("ready_low_cycles", 96'(low), 96'd3);
      check("count_11", 96'(bus.enc_count), 96'd11);

      // single-bit data injection
      bus.inj_arm  = 1'b1;
      bus.inj_mask = 72'h1;
      @(posedge clk);
      #1;
      bus.inj_arm  = 1'b0;
      bus.inj_mask = '0;
      @(negedge clk);
      check("pending_armed", 96'(bus.inj_pending), 96'd1);
      repeat (2) @(negedge clk);
      check("pending_idle", 96'(bus.inj_pending), 96'd1);
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 10'd8;
      bus.wr_data  = 64'h0;
      @(negedge clk);
      check("pending_at_accept", 96'(bus.inj_pending), 96'd1);
      @(posedge clk);
      sb.push_back('{addr: 10'd8, data: 64'h1, cb: 8'h00});
      #1;
      bus.wr_valid = 1'b0;
      @(negedge clk);
      check("pending_cleared", 96'(bus.inj_pending), 96'd0);
      @(posedge clk);
      #1;
      send(10'd9, 64'h0, 8'h00);
      wait_drain();

      // re-arm while pending: second mask replaces the first, one injection only
      bus.inj_arm  = 1'b1;
      bus.inj_mask = 72'h20;
      @(posedge clk);
      #1;
      bus.inj_mask = 72'h01_0000_0000_0000_0000;
      @(posedge clk);
      #1;
      bus.inj_arm  = 1'b0;
      bus.inj_mask = '0;
      send(10'd10, 64'h0, 8'h01);
      send(10'd11, 64'h0, 8'h00);
      wait_drain();
      check("pending_after_rearm", 96'(bus.inj_pending), 96'd0);

      // arm in the same cycle as an acceptance targets the following request
      bus.inj_arm  = 1'b1;
      bus.inj_mask = 72'h80_0000_0000_0000_0000;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 10'd12;
      bus.wr_data  = 64'h2;
      sb.push_back('{addr: 10'd12, data: 64'h2, cb: 8'h85});
      @(posedge clk);
      #1;
      bus.inj_arm  = 1'b0;
      bus.inj_mask = '0;
      bus.wr_valid = 1'b0;
      @(negedge clk);
      check("pending_same_cycle", 96'(bus.inj_pending), 96'd1);
      @(posedge clk);
      #1;
      send(10'd13, 64'h0, 8'h80);
      wait_drain();
      check("pending_final", 96'(bus.inj_pending), 96'd0);

      // reset with two writes in flight
      bus.sram_ready = 1'b0;
      send(10'd20, 64'hDEAD_BEEF_0000_0001, ref_cb(64'hDEAD_BEEF_0000_0001));
      send(10'd21, 64'hDEAD_BEEF_0000_0002, ref_cb(64'hDEAD_BEEF_0000_0002));
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      check("midrst_we", 96'(bus.sram_we), 96'd0);
      check("midrst_count", 96'(bus.enc_count), 96'd0);
      check("midrst_ready", 96'(bus.wr_ready), 96'd0);
      bus.sram_ready = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("post_rst_we", 96'(bus.sram_we), 96'd0);
      end
      check("post_rst_count", 96'(bus.enc_count), 96'd0);
      @(posedge clk);
      #1;

      // saturation of the write counter
      for (int i = 0; i < 65540; i++) begin
         d = {32'(i), ~32'(i)};
         send(ADDR_W'(i), d, ref_cb(d));
      end
      wait_drain();
      check("count_saturated", 96'(bus.enc_count), 96'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
